// File: rtl/stepper_pkg.sv
// Shared state type, coil sequence tables and step-period helper for stepper_sequencer.
// STEPPER_HALF_STEP_EN selects the 8-entry half-step sequence; otherwise full-step drive.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } step_state_e;

    // Entry i of each table sits at bits [4*i +: 4], coil order {B_n, A_n, B, A}.
    localparam logic [15:0] FULL_SEQ = {4'b1001, 4'b1100, 4'b0110, 4'b0011};
    localparam logic [31:0] HALF_SEQ = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                        4'b0110, 4'b0010, 4'b0011, 4'b0001};

`ifdef STEPPER_HALF_STEP_EN
    localparam int unsigned PH_W = 3;
`else
    localparam int unsigned PH_W = 2;
`endif

    function automatic logic [3:0] seq_coil(input logic [PH_W-1:0] idx);
`ifdef STEPPER_HALF_STEP_EN
        return HALF_SEQ[{idx, 2'b00} +: 4];
`else
        return FULL_SEQ[{idx, 2'b00} +: 4];
`endif
    endfunction

    // Level 0 never times a step; it maps to the level-1 period to avoid a divide by zero.
    function automatic int unsigned period_cycles(input int unsigned clk_hz,
                                                  input int unsigned base_hz,
                                                  input int unsigned lvl);
        int unsigned n;
        n = (lvl == 0) ? 1 : lvl;
        return clk_hz / (base_hz * n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with selectable reset value.
// stage1 exposes the first flop so callers can require two agreeing samples.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic stage1
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q      = sync_q;
    assign stage1 = meta_q;

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper motor phase sequencer with level-stepped acceleration, deceleration and reversal.
//   state  | meaning
//   IDLE   | coils off, level 0, waiting for a nonzero target
//   ACCEL  | stepping, level below effective target
//   CRUISE | stepping, level equal to effective target
//   DECEL  | stepping, level above effective target (reaching 0 returns to IDLE)
module stepper_sequencer #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BASE_STEP_HZ = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] speed,
    input  logic       dir,
    input  logic       stop,
    output logic [3:0] coil,
    output logic       running,
    output logic       step_pulse
);
    import stepper_pkg::*;

    localparam int unsigned P1 = period_cycles(CLK_HZ, BASE_STEP_HZ, 1);
    localparam int unsigned CW = (P1 > 2) ? $clog2(P1) : 1;

    logic [2:0] speed_s;
    logic [2:0] speed_s1;
    logic       dir_s;
    logic       stop_s;
    logic [1:0] ctl_stage1_unused;

    for (genvar b = 0; b < 3; b++) begin : g_speed_sync
        sync_2ff #(.RST_VAL(1'b0)) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .d      (speed[b]),
            .q      (speed_s[b]),
            .stage1 (speed_s1[b])
        );
    end

    sync_2ff #(.RST_VAL(1'b0)) u_dir_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (dir),
        .q      (dir_s),
        .stage1 (ctl_stage1_unused[0])
    );

    sync_2ff #(.RST_VAL(1'b1)) u_stop_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (stop),
        .q      (stop_s),
        .stage1 (ctl_stage1_unused[1])
    );

    // Terminal-count value (period - 1) per level, fixed at elaboration.
    logic [CW-1:0] per_last [8];
    for (genvar g = 0; g < 8; g++) begin : g_per
        assign per_last[g] = CW'(period_cycles(CLK_HZ, BASE_STEP_HZ, g) - 1);
    end

    step_state_e     state_q, state_d;
    logic [2:0]      lvl_q, lvl_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            dir_app_q, dir_app_d;
    logic [3:0]      coil_q, coil_d;
    logic            pulse_q, pulse_d;
    logic [2:0]      speed_hold_q, speed_hold_d;

    logic [2:0]      speed_acc;
    logic [2:0]      target;
    logic [2:0]      tgt_eff;
    logic [2:0]      lvl_nxt;
    logic [PH_W-1:0] phase_nxt;
    logic            step_evt;

    // A speed code is used only when both synchronizer stages agree, so single-cycle glitches are dropped.
    always_comb begin
        speed_acc    = (speed_s1 == speed_s) ? speed_s : speed_hold_q;
        speed_hold_d = speed_acc;
        target       = (stop_s || speed_acc == 3'd0) ? 3'd0 : speed_acc;
        tgt_eff      = (dir_s != dir_app_q) ? 3'd0 : target;
    end

    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        dir_app_d = dir_app_q;
        coil_d    = coil_q;
        pulse_d   = 1'b0;

        phase_nxt = dir_app_q ? (phase_q + PH_W'(1)) : (phase_q - PH_W'(1));
        lvl_nxt   = (lvl_q < tgt_eff) ? (lvl_q + 3'd1) :
                    (lvl_q > tgt_eff) ? (lvl_q - 3'd1) : lvl_q;
        step_evt  = (cnt_q == per_last[lvl_q]);

        case (state_q)
            IDLE: begin
                coil_d = 4'b0000;
                lvl_d  = 3'd0;
                cnt_d  = '0;
                if (target != 3'd0) begin
                    dir_app_d = dir_s;
                    lvl_d     = 3'd1;
                    coil_d    = seq_coil(phase_q);
                    state_d   = (target == 3'd1) ? CRUISE : ACCEL;
                end
            end
            default: begin
                if (step_evt) begin
                    cnt_d = '0;
                    lvl_d = lvl_nxt;
                    if (lvl_nxt == 3'd0) begin
                        // Final decel event parks the rotor: coils off, phase kept for the restart.
                        state_d = IDLE;
                        coil_d  = 4'b0000;
                    end else begin
                        phase_d = phase_nxt;
                        coil_d  = seq_coil(phase_nxt);
                        pulse_d = 1'b1;
                        state_d = (lvl_nxt < tgt_eff) ? ACCEL :
                                  (lvl_nxt > tgt_eff) ? DECEL : CRUISE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lvl_q        <= 3'd0;
            cnt_q        <= '0;
            phase_q      <= '0;
            dir_app_q    <= 1'b0;
            coil_q       <= 4'b0000;
            pulse_q      <= 1'b0;
            speed_hold_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            lvl_q        <= lvl_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            dir_app_q    <= dir_app_d;
            coil_q       <= coil_d;
            pulse_q      <= pulse_d;
            speed_hold_q <= speed_hold_d;
        end
    end

    assign coil       = coil_q;
    assign running    = (state_q != IDLE);
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Bench for stepper_sequencer: directed motion profiles plus randomized input traffic,
// all outputs compared every cycle against a behavioural step-timing model.
module tb_stepper_sequencer;

    localparam int unsigned CLK_HZ  = 1000;
    localparam int unsigned BASE_HZ = 10;
`ifdef STEPPER_HALF_STEP_EN
    localparam int SEQ_LEN = 8;
`else
    localparam int SEQ_LEN = 4;
`endif
    localparam int W_PULSE  = 0;
    localparam int W_RUN_HI = 1;
    localparam int W_RUN_LO = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] speed = 3'd0;
    logic       dir   = 1'b0;
    logic       stop  = 1'b1;
    logic [3:0] coil;
    logic       running;
    logic       step_pulse;

    stepper_sequencer #(.CLK_HZ(CLK_HZ), .BASE_STEP_HZ(BASE_HZ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .speed      (speed),
        .dir        (dir),
        .stop       (stop),
        .coil       (coil),
        .running    (running),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [3:0] seq_tab [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx(input int p);
        return ((p % SEQ_LEN) + SEQ_LEN) % SEQ_LEN;
    endfunction

    function automatic int period(input int n);
        return int'(CLK_HZ / (BASE_HZ * n));
    endfunction

    // Behavioural model: motor level, elapsed cycles in the current step, phase count,
    // and the last two input samples seen by the two-stage synchronizer.
    bit         m_run, m_dir, m_pulse;
    int         m_lvl, m_phase, m_elapsed;
    logic [2:0] h1_speed, h2_speed, m_held;
    bit         h1_dir, h2_dir, h1_stop, h2_stop;

    task automatic model_reset();
        m_run = 0; m_dir = 0; m_pulse = 0;
        m_lvl = 0; m_phase = 0; m_elapsed = 0;
        h1_speed = 3'd0; h2_speed = 3'd0; m_held = 3'd0;
        h1_dir = 0; h2_dir = 0; h1_stop = 1; h2_stop = 1;
    endtask

    task automatic model_edge();
        int tgt, eff, nxt;
        logic [2:0] acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc    = (h1_speed == h2_speed) ? h2_speed : m_held;
        m_held = acc;
        tgt    = (h2_stop || acc == 3'd0) ? 0 : int'(acc);
        m_pulse = 0;
        if (!m_run) begin
            if (tgt > 0) begin
                m_run = 1; m_dir = h2_dir; m_lvl = 1; m_elapsed = 0;
            end
        end else begin
            m_elapsed++;
            if (m_elapsed == period(m_lvl)) begin
                m_elapsed = 0;
                eff = (h2_dir != m_dir) ? 0 : tgt;
                nxt = m_lvl + ((eff > m_lvl) ? 1 : (eff < m_lvl) ? -1 : 0);
                m_lvl = nxt;
                if (nxt == 0) begin
                    m_run = 0;
                end else begin
                    m_phase = idx(m_phase + (m_dir ? 1 : -1));
                    m_pulse = 1;
                end
            end
        end
        h2_speed = h1_speed; h2_dir = h1_dir; h2_stop = h1_stop;
        h1_speed = speed;    h1_dir = dir;    h1_stop = stop;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
        chk("coil", 32'(coil), 32'(m_run ? seq_tab[m_phase] : 4'b0000));
        chk("running", 32'(running), 32'(m_run));
        chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
    endtask

    task automatic wait_for(input int what, input int limit, output int gap);
        bit hit;
        gap = 0;
        hit = 0;
        while (!hit && gap <= limit) begin
            tick();
            gap++;
            case (what)
                W_PULSE:  hit = (step_pulse === 1'b1);
                W_RUN_HI: hit = (running === 1'b1);
                default:  hit = (running === 1'b0);
            endcase
        end
    endtask

    task automatic expect_pulse(input string tag, input int gap_exp, input int ph);
        int g;
        wait_for(W_PULSE, 300, g);
        chk(tag, 32'(g), 32'(gap_exp));
        chk({tag, "_coil"}, 32'(coil), 32'(seq_tab[idx(ph)]));
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_coil"}, 32'(coil), 32'(4'b0000));
        chk({tag, "_pulse"}, 32'(step_pulse), 32'(1'b0));
        chk({tag, "_running"}, 32'(running), 32'(1'b0));
        model_reset();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, ph, cnt, npulse;
`ifdef STEPPER_HALF_STEP_EN
        seq_tab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
`else
        seq_tab = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
        model_reset();

        // Reset state, then forward start at level 3 with acceleration profile.
        speed = 3'd3; dir = 1'b1; stop = 1'b0;
        repeat (3) tick();
        chk("rst_coil", 32'(coil), 32'(4'b0000));
        chk("rst_running", 32'(running), 32'(1'b0));
        chk("rst_pulse", 32'(step_pulse), 32'(1'b0));
        rst_n = 1'b1;
        wait_for(W_RUN_HI, 10, g);
        chk("start_latency", 32'(g), 32'(3));
        chk("start_coil", 32'(coil), 32'(seq_tab[0]));
        ph = 0;
        expect_pulse("accel_gap1", 100, ++ph);
        expect_pulse("accel_gap2", 50, ++ph);
        expect_pulse("cruise_gap1", 33, ++ph);
        expect_pulse("cruise_gap2", 33, ++ph);

        // Stop while cruising at 3: 33, 50, then 100 to IDLE without a phase advance.
        stop = 1'b1;
        expect_pulse("decel_gap3", 33, ++ph);
        expect_pulse("decel_gap2", 50, ++ph);
        wait_for(W_RUN_LO, 200, g);
        chk("decel_gap1", 32'(g), 32'(100));
        chk("idle_coil", 32'(coil), 32'(4'b0000));

        // Restart at 2 forward, then reverse: decelerate to IDLE and restart backwards.
        stop = 1'b0; speed = 3'd2; dir = 1'b1;
        wait_for(W_RUN_HI, 10, g);
        chk("restart_latency", 32'(g), 32'(3));
        chk("restart_coil", 32'(coil), 32'(seq_tab[idx(ph)]));
        expect_pulse("fwd2_gap1", 100, ++ph);
        expect_pulse("fwd2_gap2", 50, ++ph);
        dir = 1'b0;
        expect_pulse("rev_decel", 50, ++ph);
        wait_for(W_RUN_LO, 200, g);
        chk("rev_idle_gap", 32'(g), 32'(100));
        wait_for(W_RUN_HI, 10, g);
        chk("rev_restart", 32'(g), 32'(1));
        chk("rev_restart_coil", 32'(coil), 32'(seq_tab[idx(ph)]));
        expect_pulse("rev_gap1", 100, --ph);
        expect_pulse("rev_gap2", 50, --ph);

        // Step up to 3, then glitch speed 3/5 on alternate cycles: level must hold at 3.
        speed = 3'd3;
        expect_pulse("up3_gap1", 50, --ph);
        expect_pulse("up3_gap2", 33, --ph);
        cnt = 0; npulse = 0;
        for (int k = 0; k < 140; k++) begin
            speed = k[0] ? 3'd5 : 3'd3;
            tick();
            cnt++;
            if (step_pulse === 1'b1) begin
                chk("glitch_gap", 32'(cnt), 32'(33));
                cnt = 0;
                npulse++;
            end
        end
        chk("glitch_pulses", 32'(npulse), 32'(4));
        speed = 3'd3;

        // Reset mid-cruise: coils drop at once; motion restarts from level 1 and phase 0.
        repeat (10) tick();
        async_reset("mid_reset");
        dir = 1'b1; stop = 1'b0; speed = 3'd3;
        repeat (3) tick();
        rst_n = 1'b1;
        wait_for(W_RUN_HI, 10, g);
        chk("post_reset_latency", 32'(g), 32'(3));
        chk("post_reset_coil", 32'(coil), 32'(seq_tab[0]));
        expect_pulse("post_reset_gap", 100, 1);

        // Randomized traffic: holds, speed glitches, direction flips, stops and resets.
        for (int seg = 0; seg < 60; seg++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            if (mode == 0) begin
                async_reset("rand_reset");
                repeat ($urandom_range(1, 4)) tick();
                rst_n = 1'b1;
            end else if (mode == 1) begin
                repeat ($urandom_range(10, 60)) begin
                    speed = speed ^ 3'($urandom_range(1, 7));
                    tick();
                end
            end else begin
                speed = 3'($urandom);
                if ($urandom_range(0, 3) == 0) dir = ~dir;
                stop = ($urandom_range(0, 4) == 0);
                repeat ($urandom_range(1, 400)) tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
